sata_gen_negotiator: RTL and testbench
======================================

Name: sata_gen_negotiator

Overview:
- Sequences SATA link establishment by driving the transceiver reconfiguration command interface (cmd_reconfig / cmd_sata_gen / cmd_ready) and the transceiver reset.
- Starts at the highest allowed generation and retries a bounded number of times per generation.
- On repeated link timeout, steps down GEN3 -> GEN2 -> GEN1.
- Sits between the PHY control layer (OOB/link-up status) and the Arria V reconfiguration sequencer.

Parameters:
LINK_TIMEOUT, 1000000, cycles to wait for phy_linkup after transceiver reset release (>= 2)
XRST_LEN, 16, cycles xcvr_reset is held asserted per attempt (>= 1)
RETRIES, 2, link attempts per generation before stepping down (>= 1)

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
enable  input  1  level; high = negotiate and hold link, low = return to idle
max_gen  input  2  highest generation to try, `SATA_GEN1/2/3 encoding from sata_defs.svh
phy_linkup  input  1  link-up status from OOB/PHY layer, synchronous to clk
cmd_reconfig  output  1  one-cycle reconfiguration request
cmd_sata_gen  output  2  generation for the request, stable while cmd_reconfig is high
cmd_ready  input  1  reconfiguration sequencer idle/ready
xcvr_reset  output  1  transceiver reset request
link_ready  output  1  link established at cur_gen
cur_gen  output  2  generation currently configured or being tried
neg_fail  output  1  all generations exhausted
busy  output  1  negotiation in progress (state not IDLE/LINKED/FAIL)

Behaviour:
- Reset values:
  - cmd_reconfig=0, xcvr_reset=1, link_ready=0, neg_fail=0, busy=0.
  - cur_gen=`SATA_GEN3; gen register=`SATA_GEN3.
  - Attempt and timer counters = 0. State = IDLE.
- All outputs are registered; each reflects the next state one cycle after the transition decision.
- max_gen is sampled on IDLE->REQ and on LINKED->REQ only. Any value other than GEN2/GEN3 is treated as GEN1.
- IDLE:
  - xcvr_reset=1.
  - enable=1 -> REQ with gen=max_gen and attempt counter cleared.
- REQ:
  - Wait for cmd_ready=1, then assert cmd_reconfig for exactly one cycle with cmd_sata_gen=gen, and go to ACK.
  - cur_gen updates to gen in the same cycle.
- ACK: wait one cycle (the sequencer drops cmd_ready one cycle after the request), then go to RCFG.
- RCFG:
  - Wait for cmd_ready=1, then go to XRST with the XRST_LEN counter cleared.
  - enable=0 is ignored in REQ-after-request, ACK and RCFG; a reconfiguration is never aborted.
- XRST:
  - xcvr_reset=1 for XRST_LEN cycles, then go to WAIT with the timer cleared.
- WAIT:
  - xcvr_reset=0; the timer increments each cycle.
  - phy_linkup=1 -> LINKED. phy_linkup takes priority over a timeout in the same cycle.
  - Timer reaches LINK_TIMEOUT-1 with no link-up:
    - attempt+1 < RETRIES -> attempt++, go to XRST at the same gen.
    - Otherwise attempt=0:
      - gen=GEN3 -> gen=GEN2, go to REQ.
      - gen=GEN2 -> gen=GEN1, go to REQ.
      - gen=GEN1 -> FAIL.
- LINKED:
  - link_ready=1, xcvr_reset=0.
  - phy_linkup=0 -> REQ with gen=max_gen and attempt=0. link_ready drops the next cycle.
- FAIL:
  - neg_fail=1, xcvr_reset=1.
  - Held until enable=0, then IDLE.
- enable=0 in IDLE, XRST, WAIT or LINKED -> IDLE next cycle; link_ready and neg_fail clear.
- Asynchronous reset mid-operation: immediate return to reset values, including during an outstanding reconfiguration. The sequencer is reset from the same source.
- Counter widths: $clog2(LINK_TIMEOUT), $clog2(XRST_LEN+1), $clog2(RETRIES+1). No wrap occurs because every counter is cleared on state entry.

Test Plan:
- Basic link at GEN3: max_gen=GEN3, enable=1, cmd_ready=1, phy_linkup rises 100 cycles after xcvr_reset falls -> exactly one cmd_reconfig pulse with cmd_sata_gen=GEN3, xcvr_reset low after 16 cycles, link_ready=1, cur_gen=GEN3.
- Step-down: LINK_TIMEOUT=50, RETRIES=2, phy_linkup only in the GEN1 window -> reconfig pulses GEN3, GEN2, GEN1 (3 total), 2 xcvr_reset pulses per gen before GEN1 links, link_ready=1 at cur_gen=GEN1.
- Exhaustion: phy_linkup=0 forever -> neg_fail=1 after 6 timeouts. Drop enable -> IDLE, neg_fail=0, xcvr_reset=1.
- Link loss: while LINKED at GEN2 with max_gen=GEN3, drop phy_linkup -> link_ready=0 next cycle, new cmd_reconfig with GEN3.
- Handshake hold: cmd_ready held low 40 cycles at REQ -> no cmd_reconfig until cmd_ready=1. Deassert enable during RCFG -> controller waits for cmd_ready before returning to IDLE.
- Simultaneous events: phy_linkup rises on the timeout cycle -> LINKED with no retry. Assert async reset during XRST -> all outputs at reset values immediately.

Source files
------------

// File: rtl/sata_gen_negotiator.sv
`timescale 1ns/1ps
//-----------------------------------------------------------------------------
// sata_gen_negotiator
//
// Purpose:
//   Brings up a SATA link by driving the transceiver reconfiguration command
//   interface and the transceiver reset. Negotiation starts at the highest
//   allowed generation. Each generation gets RETRIES link attempts. When all
//   attempts at a generation time out, the block steps down
//   GEN3 -> GEN2 -> GEN1. It reports failure once GEN1 is exhausted.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   enable            high = negotiate and hold the link, low = return to idle
//   max_gen           highest generation to try (GEN2/GEN3, anything else = GEN1)
//   phy_linkup        link-up status from the OOB/PHY layer
//   cmd_reconfig      one-cycle reconfiguration request
//   cmd_sata_gen      generation carried by the request
//   cmd_ready         reconfiguration sequencer idle/ready
//   xcvr_reset        transceiver reset request
//   link_ready        link established at cur_gen
//   cur_gen           generation currently configured or being tried
//   neg_fail          every generation was exhausted
//   busy              negotiation in progress
//   dbg_state         current FSM state, for observation only
//
// Reconfiguration handshake:
//   A request is issued only while cmd_ready=1. cmd_reconfig is high for
//   exactly one cycle, and cmd_sata_gen holds the requested generation during
//   that cycle. The sequencer drops cmd_ready in the cycle after the request.
//   Completion is signalled by cmd_ready returning to 1. Once a request is
//   issued, it always runs to completion.
//-----------------------------------------------------------------------------
`ifndef SATA_GEN1
`define SATA_GEN1 2'd1
`endif
`ifndef SATA_GEN2
`define SATA_GEN2 2'd2
`endif
`ifndef SATA_GEN3
`define SATA_GEN3 2'd3
`endif

module sata_gen_negotiator #(
  parameter int LINK_TIMEOUT = 1000000,
  parameter int XRST_LEN     = 16,
  parameter int RETRIES      = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] max_gen,
  input  logic       phy_linkup,
  output logic       cmd_reconfig,
  output logic [1:0] cmd_sata_gen,
  input  logic       cmd_ready,
  output logic       xcvr_reset,
  output logic       link_ready,
  output logic [1:0] cur_gen,
  output logic       neg_fail,
  output logic       busy,
  output logic [2:0] dbg_state
);

  localparam int TW = (LINK_TIMEOUT > 2) ? $clog2(LINK_TIMEOUT) : 1;
  localparam int XW = (XRST_LEN > 1) ? $clog2(XRST_LEN + 1) : 1;
  localparam int AW = (RETRIES > 1) ? $clog2(RETRIES + 1) : 1;

  localparam logic [TW-1:0] TIMER_LAST = TW'(LINK_TIMEOUT - 1);
  localparam logic [XW-1:0] XRST_LAST  = XW'(XRST_LEN - 1);
  localparam logic [AW-1:0] ATT_LAST   = AW'(RETRIES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_ACK    = 3'd2,
    S_RCFG   = 3'd3,
    S_XRST   = 3'd4,
    S_WAIT   = 3'd5,
    S_LINKED = 3'd6,
    S_FAIL   = 3'd7
  } state_t;

  state_t          r_state;
  logic [1:0]      r_gen;
  logic [1:0]      r_cur_gen;
  logic [AW-1:0]   r_attempt;
  logic [TW-1:0]   r_timer;
  logic [XW-1:0]   r_xcnt;
  logic            r_cmd_reconfig;
  logic            r_xcvr_reset;
  logic            r_link_ready;
  logic            r_neg_fail;
  logic            r_busy;
  logic [1:0]      w_max_gen;

  // Any encoding other than GEN2/GEN3 falls back to GEN1.
  assign w_max_gen = (max_gen == `SATA_GEN2 || max_gen == `SATA_GEN3) ? max_gen : `SATA_GEN1;

  // Outputs are registered together with the state. Each one therefore
  // reflects the state entered at the last clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_gen          <= `SATA_GEN3;
      r_cur_gen      <= `SATA_GEN3;
      r_attempt      <= '0;
      r_timer        <= '0;
      r_xcnt         <= '0;
      r_cmd_reconfig <= 1'b0;
      r_xcvr_reset   <= 1'b1;
      r_link_ready   <= 1'b0;
      r_neg_fail     <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_cmd_reconfig <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state   <= S_REQ;
            r_gen     <= w_max_gen;
            r_attempt <= '0;
            r_busy    <= 1'b1;
          end
        end
        S_REQ: begin
          // No request has been issued yet, so dropping enable here is safe.
          if (!enable) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (cmd_ready) begin
            r_state        <= S_ACK;
            r_cmd_reconfig <= 1'b1;
            r_cur_gen      <= r_gen;
          end
        end
        S_ACK: r_state <= S_RCFG;
        S_RCFG: begin
          if (cmd_ready) begin
            r_state <= S_XRST;
            r_xcnt  <= '0;
          end
        end
        S_XRST: begin
          if (!enable) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_xcnt == XRST_LAST) begin
            r_state      <= S_WAIT;
            r_timer      <= '0;
            r_xcvr_reset <= 1'b0;
          end else begin
            r_xcnt <= r_xcnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (!enable) begin
            r_state      <= S_IDLE;
            r_xcvr_reset <= 1'b1;
            r_busy       <= 1'b0;
          end else if (phy_linkup) begin
            // Link-up wins over a timeout that lands in the same cycle.
            r_state      <= S_LINKED;
            r_link_ready <= 1'b1;
            r_busy       <= 1'b0;
          end else if (r_timer == TIMER_LAST) begin
            r_xcvr_reset <= 1'b1;
            if (r_attempt != ATT_LAST) begin
              r_attempt <= r_attempt + 1'b1;
              r_state   <= S_XRST;
              r_xcnt    <= '0;
            end else begin
              r_attempt <= '0;
              case (r_gen)
                `SATA_GEN3: begin
                  r_gen   <= `SATA_GEN2;
                  r_state <= S_REQ;
                end
                `SATA_GEN2: begin
                  r_gen   <= `SATA_GEN1;
                  r_state <= S_REQ;
                end
                default: begin
                  r_state    <= S_FAIL;
                  r_neg_fail <= 1'b1;
                  r_busy     <= 1'b0;
                end
              endcase
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_LINKED: begin
          if (!enable) begin
            r_state      <= S_IDLE;
            r_link_ready <= 1'b0;
            r_xcvr_reset <= 1'b1;
          end else if (!phy_linkup) begin
            // Link lost: renegotiate from the top allowed generation.
            r_state      <= S_REQ;
            r_gen        <= w_max_gen;
            r_attempt    <= '0;
            r_link_ready <= 1'b0;
            r_xcvr_reset <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        S_FAIL: begin
          if (!enable) begin
            r_state    <= S_IDLE;
            r_neg_fail <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_reconfig = r_cmd_reconfig;
  assign cmd_sata_gen = r_cur_gen;
  assign xcvr_reset   = r_xcvr_reset;
  assign link_ready   = r_link_ready;
  assign cur_gen      = r_cur_gen;
  assign neg_fail     = r_neg_fail;
  assign busy         = r_busy;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_sata_gen_negotiator.sv
`timescale 1ns/1ps
//-----------------------------------------------------------------------------
// tb_sata_gen_negotiator
//
// Drives sata_gen_negotiator with a reactive reconfiguration sequencer and a
// reactive PHY. For each scenario, the expected sequence of reconfiguration
// generations and xcvr_reset low-phase lengths is derived up front from the
// negotiation rules, and the observed events are scored against that plan.
//-----------------------------------------------------------------------------
module tb_sata_gen_negotiator;

  localparam int LT = 50;
  localparam int XL = 16;
  localparam int RT = 2;
  localparam logic [1:0] G1 = 2'd1;
  localparam logic [1:0] G2 = 2'd2;
  localparam logic [1:0] G3 = 2'd3;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [1:0] max_gen;
  logic       phy_linkup;
  logic       cmd_ready;
  logic       cmd_reconfig;
  logic [1:0] cmd_sata_gen;
  logic       xcvr_reset;
  logic       link_ready;
  logic [1:0] cur_gen;
  logic       neg_fail;
  logic       busy;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  sata_gen_negotiator #(
    .LINK_TIMEOUT(LT),
    .XRST_LEN(XL),
    .RETRIES(RT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .max_gen(max_gen),
    .phy_linkup(phy_linkup),
    .cmd_reconfig(cmd_reconfig),
    .cmd_sata_gen(cmd_sata_gen),
    .cmd_ready(cmd_ready),
    .xcvr_reset(xcvr_reset),
    .link_ready(link_ready),
    .cur_gen(cur_gen),
    .neg_fail(neg_fail),
    .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];      // expected reconfiguration generations
  int         exp_low_q[$];  // expected xcvr_reset low-phase lengths
  bit         exp_fail;
  int         exp_falls;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [1:0] norm_gen(input logic [1:0] g);
    return (g == G2 || g == G3) ? g : G1;
  endfunction

  // ---------------- monitor / reactive model state ----------------
  int         cyc = 0;
  logic       p_rcfg, p_xrst, p_lr, p_nf;
  int         low_len, high_len;
  int         rcfg_cyc, rcfg_b, seq_cnt, rdy_force;
  bit         rcfg_seen, scen_on;
  logic [1:0] phy_gen;
  int         att_idx, link_at;
  int         n_rcfg, n_falls;
  logic [1:0] plan_gen;
  int         plan_att, plan_k;

  // Build the expected event plan. The link comes up at generation lg on
  // attempt la, k cycles after reset release. lg = 0 means the link never
  // comes up.
  task automatic plan(input logic [1:0] mg, input logic [1:0] lg, input int la, input int lk);
    int st;
    st = int'(norm_gen(mg));
    exp_q.delete();
    exp_low_q.delete();
    exp_fail  = 1'b1;
    exp_falls = 0;
    plan_gen  = lg;
    plan_att  = la;
    plan_k    = lk;
    for (int gi = st; gi >= 1; gi--) begin
      exp_q.push_back(2'(gi));
      if (gi == int'(lg)) begin
        for (int i = 0; i < la; i++) exp_low_q.push_back(LT);
        exp_low_q.push_back(lk);
        exp_falls += la + 1;
        exp_fail = 1'b0;
        break;
      end
      for (int i = 0; i < RT; i++) exp_low_q.push_back(LT);
      exp_falls += RT;
    end
  endtask

  // One clock cycle: sample at the falling edge, score, then drive the
  // reactive sequencer and PHY for the next rising edge.
  task automatic tick();
    logic [1:0] e;
    int el;
    @(negedge clk);
    cyc++;
    if (!xcvr_reset) begin
      if (p_xrst) begin
        n_falls++;
        if (rcfg_seen) check_val("rcfg_to_release", cyc - rcfg_cyc, rcfg_b + 1 + XL);
        else check_val("retry_reset_len", high_len, XL);
        rcfg_seen = 1'b0;
        low_len   = 1;
        link_at   = (phy_gen == plan_gen && att_idx == plan_att) ? plan_k : 0;
        att_idx++;
      end else begin
        low_len++;
      end
    end else begin
      if (!p_xrst) begin
        if (!p_lr) begin
          check_val("timeout_expected", exp_low_q.size() > 0, 1);
          if (exp_low_q.size() > 0) begin
            el = exp_low_q.pop_front();
            check_val("timeout_len", low_len, el);
          end
        end
        high_len = 1;
      end else begin
        high_len++;
      end
    end
    if (link_ready && !p_lr) begin
      check_val("link_expected", exp_low_q.size() > 0, 1);
      if (exp_low_q.size() > 0) begin
        el = exp_low_q.pop_front();
        check_val("link_latency", low_len, el + 1);
      end
    end
    if (neg_fail && !p_nf) check_val("fail_expected", exp_fail, 1);
    if (cmd_reconfig) begin
      check_val("rcfg_one_cycle", p_rcfg, 0);
      n_rcfg++;
      check_val("rcfg_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_val("rcfg_gen", cmd_sata_gen, e);
        check_val("cur_gen_at_rcfg", cur_gen, e);
      end
      phy_gen   = cmd_sata_gen;
      att_idx   = 0;
      rcfg_seen = 1'b1;
      rcfg_cyc  = cyc;
      rcfg_b    = (rdy_force > 0) ? rdy_force : int'($urandom_range(5, 1));
      cmd_ready = 1'b0;
      seq_cnt   = rcfg_b;
    end else if (seq_cnt > 0) begin
      seq_cnt--;
      if (seq_cnt == 0) cmd_ready = 1'b1;
    end
    if (!xcvr_reset && link_at > 0 && low_len == link_at) phy_linkup = 1'b1;
    if (scen_on) check_val("busy", busy, !(link_ready || neg_fail));
    p_rcfg = cmd_reconfig;
    p_xrst = xcvr_reset;
    p_lr   = link_ready;
    p_nf   = neg_fail;
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_scen(input logic [1:0] mg, input logic [1:0] lg, input int la, input int lk);
    plan(mg, lg, la, lk);
    n_rcfg  = 0;
    n_falls = 0;
    max_gen = mg;
    scen_on = 1'b1;
    enable  = 1'b1;
  endtask

  task automatic finish_scen();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 1500 && !done; i++) begin
      tick();
      done = link_ready || neg_fail;
    end
    check_val("scen_complete", done, 1);
    if (exp_fail) begin
      check_val("neg_fail", neg_fail, 1);
      check_val("fail_xcvr_reset", xcvr_reset, 1);
      check_val("fail_link_ready", link_ready, 0);
    end else begin
      check_val("link_ready", link_ready, 1);
      check_val("link_gen", cur_gen, plan_gen);
      check_val("linked_xcvr_reset", xcvr_reset, 0);
    end
    check_val("rcfg_left", exp_q.size(), 0);
    check_val("phase_left", exp_low_q.size(), 0);
    check_val("reset_pulses", n_falls, exp_falls);
  endtask

  task automatic end_scen();
    scen_on    = 1'b0;
    enable     = 1'b0;
    phy_linkup = 1'b0;
    tick();
    tick();
    check_val("idle_busy", busy, 0);
    check_val("idle_link_ready", link_ready, 0);
    check_val("idle_neg_fail", neg_fail, 0);
    check_val("idle_xcvr_reset", xcvr_reset, 1);
    link_at   = 0;
    rdy_force = 0;
    exp_q.delete();
    exp_low_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_cmd_reconfig"}, cmd_reconfig, 0);
    check_val({tag, "_xcvr_reset"}, xcvr_reset, 1);
    check_val({tag, "_link_ready"}, link_ready, 0);
    check_val({tag, "_neg_fail"}, neg_fail, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_cur_gen"}, cur_gen, G3);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0] r_mg, r_lg;
    int r_la, r_lk, r_st;
    bit seen;

    reset = 1'b1; enable = 1'b0; max_gen = G3; phy_linkup = 1'b0; cmd_ready = 1'b1;
    p_rcfg = 1'b0; p_xrst = 1'b1; p_lr = 1'b0; p_nf = 1'b0;
    low_len = 0; high_len = 0; rcfg_cyc = 0; rcfg_b = 0; seq_cnt = 0; rdy_force = 0;
    rcfg_seen = 1'b0; scen_on = 1'b0; phy_gen = G3; att_idx = 0; link_at = 0;
    n_rcfg = 0; n_falls = 0; plan_gen = 2'd0; plan_att = 0; plan_k = 0;
    exp_fail = 1'b0; exp_falls = 0;
    repeat (3) @(negedge clk);
    check_reset_values("por");
    reset = 1'b0;
    tick();

    // Basic link at GEN3 on the first attempt.
    start_scen(G3, G3, 0, 30);
    finish_scen();
    check_val("basic_rcfg_count", n_rcfg, 1);
    end_scen();

    // Step-down to GEN1, linking on the second GEN1 attempt.
    start_scen(G3, G1, 1, 20);
    finish_scen();
    check_val("stepdown_rcfg_count", n_rcfg, 3);
    end_scen();

    // Exhaustion: the link never comes up.
    start_scen(G3, 2'd0, 0, 0);
    finish_scen();
    check_val("exhaust_rcfg_count", n_rcfg, 3);
    end_scen();

    // Link loss at GEN2 with max_gen raised to GEN3 while linked.
    start_scen(G2, G2, 0, 10);
    finish_scen();
    max_gen = G3;
    plan(G3, G3, 0, 25);
    n_rcfg = 0; n_falls = 0;
    phy_linkup = 1'b0;
    tick();
    check_val("loss_link_ready", link_ready, 0);
    check_val("loss_xcvr_reset", xcvr_reset, 1);
    finish_scen();
    check_val("loss_rcfg_count", n_rcfg, 1);
    end_scen();

    // cmd_ready held low at REQ: no request goes out.
    cmd_ready = 1'b0;
    start_scen(G2, G2, 0, 5);
    repeat (40) tick();
    check_val("hold_no_rcfg", n_rcfg, 0);
    check_val("hold_busy", busy, 1);
    cmd_ready = 1'b1;
    finish_scen();
    check_val("hold_rcfg_count", n_rcfg, 1);
    end_scen();

    // enable dropped during reconfiguration: it must run to completion.
    rdy_force = 6;
    start_scen(G1, G1, 0, 5);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = cmd_reconfig;
    end
    check_val("rcfg_issued", seen, 1);
    enable  = 1'b0;
    scen_on = 1'b0;
    for (int i = 0; i < 20 && !cmd_ready; i++) begin
      tick();
      check_val("rcfg_hold_busy", busy, 1);
    end
    tick();
    tick();
    check_val("rcfg_abort_busy", busy, 0);
    check_val("rcfg_abort_xcvr_reset", xcvr_reset, 1);
    check_val("rcfg_abort_falls", n_falls, 0);
    end_scen();

    // Link-up lands exactly on the timeout cycle.
    start_scen(G3, G3, 0, LT);
    finish_scen();
    check_val("simul_rcfg_count", n_rcfg, 1);
    end_scen();

    // Randomized scenarios.
    for (int s = 0; s < 8; s++) begin
      r_mg = 2'($urandom_range(3, 0));
      r_st = int'(norm_gen(r_mg));
      r_lg = 2'($urandom_range(r_st, 0));
      r_la = $urandom_range(RT - 1, 0);
      r_lk = ($urandom_range(3, 0) == 0) ? LT : int'($urandom_range(LT, 1));
      start_scen(r_mg, r_lg, r_la, r_lk);
      finish_scen();
      end_scen();
    end

    // Asynchronous reset while the transceiver reset is being held.
    start_scen(G1, G1, 0, 5);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = cmd_reconfig;
    end
    for (int i = 0; i < 20 && !cmd_ready; i++) tick();
    repeat (3) tick();
    check_val("pre_reset_gen", cur_gen, G1);
    scen_on = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("async");
    cmd_ready = 1'b1;
    seq_cnt = 0;
    enable = 1'b0;
    @(negedge clk);
    check_reset_values("async_hold");
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
